// File: rtl/decryption_block.sv
// rtl/decryption_block.sv - iterative AES-128 inverse cipher, one inverse round per clock
// Key schedule runs forward to rk10, then unwinds one round key per edge alongside the rounds.
module decryption_block (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         decryptEnable,
  input  logic [127:0] key,
  input  logic [127:0] inputData,
  output logic [127:0] outputData,
  output logic         decryptDone
);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY_EXPAND, S_ADD_INIT, S_ROUND, S_FINAL, S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [127:0] data_q;
  logic [127:0] key_q;
  logic [3:0]   kr_q;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [31:0]  w0, w1, w2, w3, iw3, sub_in, sub_out;
  logic [7:0]   rc;
  logic [127:0] key_fwd, key_inv;

  // One SubWord/RotWord unit serves both the forward and the inverse key step
  always_comb begin
    w0      = key_q[127:96];
    w1      = key_q[95:64];
    w2      = key_q[63:32];
    w3      = key_q[31:0];
    iw3     = w3 ^ w2;
    sub_in  = (state_q == S_KEY_EXPAND) ? w3 : iw3;
    rc      = rcon((state_q == S_KEY_EXPAND) ? kr_q : kr_q - 4'd1);
    sub_out = {sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0]), sbox(sub_in[31:24])}
              ^ {rc, 24'h000000};
    key_fwd[127:96] = w0 ^ sub_out;
    key_fwd[95:64]  = w1 ^ key_fwd[127:96];
    key_fwd[63:32]  = w2 ^ key_fwd[95:64];
    key_fwd[31:0]   = w3 ^ key_fwd[63:32];
    key_inv         = {w0 ^ sub_out, w1 ^ w0, w2 ^ w1, iw3};
  end

  logic [127:0] isr, isb, ark, imc;

  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    isr = '0;
    isb = '0;
    imc = '0;
    a0  = '0;
    a1  = '0;
    a2  = '0;
    a3  = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        isr[127-8*(r+4*c) -: 8] = data_q[127-8*(r+4*((c-r+4)%4)) -: 8];
    for (int i = 0; i < 16; i++)
      isb[127-8*i -: 8] = inv_sbox(isr[127-8*i -: 8]);
    ark = isb ^ key_q;
    for (int c = 0; c < 4; c++) begin
      a0 = ark[127-32*c -: 8];
      a1 = ark[119-32*c -: 8];
      a2 = ark[111-32*c -: 8];
      a3 = ark[103-32*c -: 8];
      imc[127-32*c -: 32] = {
        gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
        gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
        gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
        gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // kr_q tracks which round key currently sits in key_q
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (decryptEnable) state_d = S_KEY_EXPAND;
      S_KEY_EXPAND: if (kr_q == 4'd9) state_d = S_ADD_INIT;
      S_ADD_INIT:   state_d = S_ROUND;
      S_ROUND:      if (kr_q == 4'd1) state_d = S_FINAL;
      S_FINAL:      state_d = S_DONE;
      S_DONE:       if (!decryptEnable) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_q     <= '0;
      key_q      <= '0;
      kr_q       <= '0;
      outputData <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (decryptEnable) begin
          key_q  <= key;
          data_q <= inputData;
          kr_q   <= 4'd0;
        end
        S_KEY_EXPAND: begin
          key_q <= key_fwd;
          kr_q  <= kr_q + 4'd1;
        end
        S_ADD_INIT: begin
          data_q <= data_q ^ key_q;
          key_q  <= key_inv;
          kr_q   <= kr_q - 4'd1;
        end
        S_ROUND: begin
          data_q <= imc;
          key_q  <= key_inv;
          kr_q   <= kr_q - 4'd1;
        end
        S_FINAL: outputData <= ark;
        default: ;
      endcase
    end
  end

  assign decryptDone = (state_q == S_DONE);

endmodule

// File: tb/tb_decryption_block.sv
// tb/tb_decryption_block.sv - directed-vector bench for decryption_block
module tb_decryption_block;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_RT = 128'h5e74e7ba66b0c7cc1b7697b3f9f51527;
  localparam logic [127:0] CT_RT  = 128'hdeb0f81341f3503a7cd01e2bc7cdd556;
  localparam logic [127:0] PT_RT  = 128'h7d8ae0f7cfa0a6cb09fb5d05a8ec586d;

  logic         tb_clk = 1'b0;
  logic         n_rst;
  logic         decryptEnable;
  logic [127:0] key;
  logic [127:0] inputData;
  logic [127:0] outputData;
  logic         decryptDone;

  int n_checks = 0;
  int n_errors = 0;

  decryption_block dut (
    .clk           (tb_clk),
    .n_rst         (n_rst),
    .decryptEnable (decryptEnable),
    .key           (key),
    .inputData     (inputData),
    .outputData    (outputData),
    .decryptDone   (decryptDone)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns just after the start edge (edge 0)
  task automatic start_op(input logic [127:0] k, input logic [127:0] d);
    @(negedge tb_clk);
    key           = k;
    inputData     = d;
    decryptEnable = 1'b1;
    @(posedge tb_clk);
  endtask

  task automatic expect_result(input string tag, input logic [127:0] exp);
    repeat (20) @(posedge tb_clk);
    #1 check({tag, "_done_early"}, {127'h0, decryptDone}, 128'h0);
    @(posedge tb_clk);
    #1 check({tag, "_done"}, {127'h0, decryptDone}, 128'h1);
    check({tag, "_data"}, outputData, exp);
  endtask

  initial begin
    n_rst         = 1'b0;
    decryptEnable = 1'b0;
    key           = '0;
    inputData     = '0;
    #12;
    check("rst_data", outputData, 128'h0);
    check("rst_done", {127'h0, decryptDone}, 128'h0);
    @(negedge tb_clk);
    n_rst = 1'b1;
    repeat (3) @(posedge tb_clk);
    #1 check("idle_no_start", {127'h0, decryptDone}, 128'h0);

    start_op(KEY_C1, CT_C1);
    expect_result("c1", PT_C1);

    repeat (5) @(posedge tb_clk);
    #1 check("hold_done", {127'h0, decryptDone}, 128'h1);
    check("hold_data", outputData, PT_C1);
    @(negedge tb_clk);
    decryptEnable = 1'b0;
    @(posedge tb_clk);
    #1 check("release_done", {127'h0, decryptDone}, 128'h0);
    check("release_data", outputData, PT_C1);

    start_op(KEY_B, CT_B);
    expect_result("fips_b", PT_B);
    @(negedge tb_clk);
    decryptEnable = 1'b0;
    @(posedge tb_clk);
    #1 check("fips_b_release", {127'h0, decryptDone}, 128'h0);

    start_op(KEY_RT, CT_RT);
    expect_result("roundtrip", PT_RT);
    @(negedge tb_clk);
    decryptEnable = 1'b0;
    @(posedge tb_clk);

    start_op(KEY_C1, CT_C1);
    for (int i = 1; i <= 21; i++) begin
      @(negedge tb_clk);
      if (i == 5) begin
        key       = '1;
        inputData = '0;
      end
      if (i == 8) decryptEnable = 1'b0;
      @(posedge tb_clk);
      #1;
      if (i == 20) check("stab_done_early", {127'h0, decryptDone}, 128'h0);
    end
    check("stab_done", {127'h0, decryptDone}, 128'h1);
    check("stab_data", outputData, PT_C1);
    @(posedge tb_clk);
    #1 check("stab_release", {127'h0, decryptDone}, 128'h0);

    start_op(KEY_RT, CT_RT);
    repeat (13) @(posedge tb_clk);
    #2;
    n_rst         = 1'b0;
    decryptEnable = 1'b0;
    #1 check("midrst_data", outputData, 128'h0);
    check("midrst_done", {127'h0, decryptDone}, 128'h0);
    @(negedge tb_clk);
    n_rst = 1'b1;
    @(posedge tb_clk);
    #1 check("midrst_idle", {127'h0, decryptDone}, 128'h0);
    start_op(KEY_B, CT_B);
    expect_result("restart_b", PT_B);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
